sobel_frame_ctrl: RTL and testbench

//  Frame sequencer for the 3x3 binary Sobel edge stage. Tracks pixel position from upstream vld/sop/eop framing
//  and drives the clock-enable for the line-buffer/window registers. Flags when the 3x3 window is fully populated
//  and regenerates vld/sop/eop for the edge output. Detects malformed frames and resynchronises on the next sop.

---
 rtl/sobel_pkg.sv | 13 +
 rtl/sobel_pos_cnt.sv | 65 ++++++
 rtl/sobel_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the 3x3 binary Sobel frame sequencer.
package sobel_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int WIN_ROWS  = 3;
   localparam int WIN_COLS  = 3;
   localparam int DEF_IMG_W = 640;
   localparam int DEF_IMG_H = 480;
endpackage

// File: rtl/sobel_pos_cnt.sv
// Pixel position tracker: col/row of the pixel accepted this cycle, stored next position, wrap and last flags.
// Combinational position outputs; the stored position only moves on adv_i, so upstream stalls simply hold it.
module sobel_pos_cnt #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CW    = 10,
   parameter int RW    = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv_i,
   input  logic          restart_i,
   input  logic          clr_i,
   output logic [CW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic          col_wrap_o,
   output logic          last_o
);
   logic [CW-1:0] col_q, col_d, col_cur;
   logic [RW-1:0] row_q, row_d, row_cur;
   logic          col_wrap, last;

   // A sop pixel is always (0,0) regardless of where the stored position was.
   always_comb begin
      col_cur  = restart_i ? '0 : col_q;
      row_cur  = restart_i ? '0 : row_q;
      col_wrap = (col_cur == CW'(IMG_W - 1));
      last     = col_wrap && (row_cur == RW'(IMG_H - 1));
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (adv_i) begin
         if (last) begin
            col_d = '0;
            row_d = '0;
         end else if (col_wrap) begin
            col_d = '0;
            row_d = row_cur + RW'(1);
         end else begin
            col_d = col_cur + CW'(1);
            row_d = row_cur;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o      = col_cur;
   assign row_o      = row_cur;
   assign col_wrap_o = col_wrap;
   assign last_o     = last;
endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel stage: window enable/full flags, 1-cycle registered dout framing, error resync.
// Stalls on din_vld=0 anywhere; SOBEL_CTRL_STAT_EN adds saturating frame_cnt/err_cnt outputs.
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int CW    = 10,
   parameter int RW    = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din_vld,
   input  logic          din_sop,
   input  logic          din_eop,
   output logic          win_en,
   output logic [CW-1:0] col_cnt,
   output logic [RW-1:0] row_cnt,
   output logic          win_full,
   output logic          dout_vld,
   output logic          dout_sop,
   output logic          dout_eop,
   output logic          frame_err,
   output logic          busy
`ifdef SOBEL_CTRL_STAT_EN
   ,
   output logic [15:0]   frame_cnt,
   output logic [15:0]   err_cnt
`endif
);
   state_t state_q, state_d;
   logic   accept, restart, clr;
   logic   col_wrap, last;
   logic   err_d, eop_d, sop_d;
   logic   dout_vld_q, dout_sop_q, dout_eop_q, frame_err_q, busy_q;

   assign accept  = din_vld && ((state_q != IDLE) || din_sop);
   assign restart = accept && din_sop;

   sobel_pos_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .CW    (CW),
      .RW    (RW)
   ) u_pos (
      .clk        (clk),
      .rst        (rst),
      .adv_i      (accept),
      .restart_i  (restart),
      .clr_i      (clr),
      .col_o      (col_cnt),
      .row_o      (row_cnt),
      .col_wrap_o (col_wrap),
      .last_o     (last)
   );

   assign win_en   = accept;
   assign win_full = accept && (row_cnt >= RW'(WIN_ROWS - 1)) && (col_cnt >= CW'(WIN_COLS - 1));
   assign sop_d    = win_full && (row_cnt == RW'(WIN_ROWS - 1)) && (col_cnt == CW'(WIN_COLS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // sop has priority over eop/last: a sop pixel always restarts the frame.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      eop_d   = 1'b0;
      clr     = 1'b0;
      if (accept) begin
         if (din_sop) begin
            state_d = FILL;
            err_d   = (state_q != IDLE) || din_eop;
         end else if (last) begin
            state_d = IDLE;
            eop_d   = din_eop;
            err_d   = !din_eop;
         end else if (din_eop) begin
            state_d = IDLE;
            err_d   = 1'b1;
            clr     = 1'b1;
         end else if ((state_q == FILL) && col_wrap && (row_cnt == RW'(WIN_ROWS - 2))) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_vld_q  <= 1'b0;
         dout_sop_q  <= 1'b0;
         dout_eop_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         dout_vld_q  <= win_full;
         dout_sop_q  <= sop_d;
         dout_eop_q  <= eop_d;
         frame_err_q <= err_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign dout_vld  = dout_vld_q;
   assign dout_sop  = dout_sop_q;
   assign dout_eop  = dout_eop_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

`ifdef SOBEL_CTRL_STAT_EN
   logic [15:0] frame_cnt_q, err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (eop_d && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on an 8x6 image; registered outputs are checked through an expectation queue.
module tb_sobel_frame_ctrl;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int CW = 3;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          din_vld, din_sop, din_eop;
   logic          win_en, win_full, dout_vld, dout_sop, dout_eop, frame_err, busy;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
`ifdef SOBEL_CTRL_STAT_EN
   logic [15:0]   frame_cnt, err_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int vld_cnt = 0;
   int vld_base;
   logic [3:0] sb_q[$];

   always #5 clk = ~clk;

   sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .din_vld   (din_vld),
      .din_sop   (din_sop),
      .din_eop   (din_eop),
      .win_en    (win_en),
      .col_cnt   (col_cnt),
      .row_cnt   (row_cnt),
      .win_full  (win_full),
      .dout_vld  (dout_vld),
      .dout_sop  (dout_sop),
      .dout_eop  (dout_eop),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef SOBEL_CTRL_STAT_EN
      ,
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
`endif
   );

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Registered outputs {vld,sop,eop,err}: any nonzero cycle must match the head of the queue.
   always @(negedge clk) begin
      if (dout_vld) vld_cnt++;
      if (dout_vld || dout_sop || dout_eop || frame_err) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out: got vld/sop/eop/err=%b expected none (t=%0t)",
                     {dout_vld, dout_sop, dout_eop, frame_err}, $time);
         end else begin
            logic [3:0] e;
            e = sb_q.pop_front();
            if ({dout_vld, dout_sop, dout_eop, frame_err} != e) begin
               n_err++;
               $display("FAIL dout_flags: got vld/sop/eop/err=%b expected %b (t=%0t)",
                        {dout_vld, dout_sop, dout_eop, frame_err}, e, $time);
            end
         end
      end
   end

   // r<0 skips the position check where the stored position is not defined.
   task automatic send(input bit s, input bit e, input bit acc, input int r, input int c, input bit err);
      bit v, xs, xe;
      @(negedge clk);
      din_vld = 1'b1;
      din_sop = s;
      din_eop = e;
      #1;
      check("win_en", win_en, acc);
      if (r >= 0) begin
         check("col_cnt", col_cnt, c);
         check("row_cnt", row_cnt, r);
      end
      v  = acc && (r >= 2) && (c >= 2);
      xs = v && (r == 2) && (c == 2);
      xe = acc && !s && e && (r == H - 1) && (c == W - 1);
      check("win_full", win_full, v);
      if (v || xs || xe || err) sb_q.push_back({v, xs, xe, err});
      @(posedge clk);
      #1;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
   endtask

   task automatic gap(input int r, input int c);
      @(negedge clk);
      din_vld = 1'b0;
      #1;
      check("gap_win_en", win_en, 0);
      check("gap_win_full", win_full, 0);
      check("gap_col", col_cnt, c);
      check("gap_row", row_cnt, r);
   endtask

   task automatic pix_range(input int lo, input int hi, input bit gaps);
      for (int i = lo; i <= hi; i++) begin
         send(i == 0, i == W * H - 1, 1'b1, i / W, i % W, 1'b0);
         if (gaps) gap(((i + 1) % (W * H)) / W, ((i + 1) % (W * H)) % W);
      end
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
      #1;
      check("busy_after", busy, 0);
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_win_en", win_en, 0);
      check("rst_col", col_cnt, 0);
      check("rst_row", row_cnt, 0);
      check("rst_dout_vld", dout_vld, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      // Pixels before any sop are dropped silently.
      send(0, 0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0, 0);
      send(0, 1, 0, 0, 0, 0);
      check("presop_busy", busy, 0);

      // Clean frame, continuous valid.
      vld_base = vld_cnt;
      pix_range(0, 0, 0);
      check("busy_in_frame", busy, 1);
      pix_range(1, 47, 0);
      settle();
      check("t1_vld_count", vld_cnt - vld_base, 24);

      // Same frame with valid toggling.
      vld_base = vld_cnt;
      pix_range(0, 47, 1);
      settle();
      check("t2_vld_count", vld_cnt - vld_base, 24);

      // sop re-asserted at (3,4), then a full frame from that sop.
      pix_range(0, 27, 0);
      send(1, 0, 1, 0, 0, 1);
      check("restart_busy", busy, 1);
      pix_range(1, 47, 0);
      settle();

      // sop and eop together mid-frame: restart plus error.
      pix_range(0, 9, 0);
      send(1, 1, 1, 0, 0, 1);
      pix_range(1, 47, 0);
      settle();

      // Early eop at (5,3).
      pix_range(0, 42, 0);
      send(0, 1, 1, 5, 3, 1);
      check("early_eop_busy", busy, 0);
      send(0, 0, 0, -1, 0, 0);
      settle();

      // Last pixel without eop.
      pix_range(0, 46, 0);
      send(0, 0, 1, 5, 7, 1);
      settle();

      // Reset mid-frame right after pixel (3,2).
      pix_range(0, 26, 0);
      check("pre_rst_dout_vld", dout_vld, 1);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("midrst_dout_vld", dout_vld, 0);
      check("midrst_busy", busy, 0);
      check("midrst_col", col_cnt, 0);
      check("midrst_row", row_cnt, 0);
      check("midrst_pending", sb_q.size(), 1);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      vld_base = vld_cnt;
      pix_range(0, 47, 0);
      settle();
      check("t6_vld_count", vld_cnt - vld_base, 24);
`ifdef SOBEL_CTRL_STAT_EN
      check("frame_cnt", frame_cnt, 1);
      check("err_cnt", err_cnt, 0);
`endif

      repeat (2) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
